// File: rtl/jt053246_pkg.sv
`default_nettype none
//============================================================================
// Module      : jt053246_pkg
// Description : Shared types and constants for the k053246 draw-request
//               queue: the queued entry layout, the launch FSM states and
//               a saturating adder for the drop counter.
// Revision    : 1.0 - initial release
//============================================================================
package jt053246_pkg;

    localparam int ENTRY_W = 56;

    localparam logic [7:0] c_DROPS_MAX = 8'hFF;

    // One queued draw request, fields in the order the scanner presents them
    typedef struct packed {
        logic [15:0] code;
        logic [9:0]  attr;
        logic        hflip;
        logic        vflip;
        logic [8:0]  hpos;
        logic [3:0]  ysub;
        logic [11:0] hzoom;
        logic        hz_keep;
        logic [1:0]  shd;
    } drq_entry_t;

    // Launch sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        GUARD = 2'd2,
        WAIT  = 2'd3
    } drq_state_t;

    // 8-bit add that sticks at the maximum instead of wrapping
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? c_DROPS_MAX : s[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/jt053246_drq_if.sv
`default_nettype none
//============================================================================
// Module      : jt053246_drq_if
// Description : Scanner-side request bus and draw-engine-side launch bus of
//               the draw-request queue. The slave modport is the queue, the
//               master modport is the scanner/engine pair around it.
// Revision    : 1.0 - initial release
//============================================================================
interface jt053246_drq_if;

    // scanner side
    logic        in_start;
    logic        in_busy;
    logic [15:0] in_code;
    logic [9:0]  in_attr;
    logic        in_hflip;
    logic        in_vflip;
    logic [8:0]  in_hpos;
    logic [3:0]  in_ysub;
    logic [11:0] in_hzoom;
    logic        in_hz_keep;
    logic [1:0]  in_shd;

    // draw engine side
    logic        out_start;
    logic [15:0] out_code;
    logic [9:0]  out_attr;
    logic        out_hflip;
    logic        out_vflip;
    logic [8:0]  out_hpos;
    logic [3:0]  out_ysub;
    logic [11:0] out_hzoom;
    logic        out_hz_keep;
    logic [1:0]  out_shd;
    logic        eng_busy;
    logic        out_abort;

    modport master (
        output in_start, in_code, in_attr, in_hflip, in_vflip, in_hpos,
               in_ysub, in_hzoom, in_hz_keep, in_shd, eng_busy,
        input  in_busy, out_start, out_code, out_attr, out_hflip, out_vflip,
               out_hpos, out_ysub, out_hzoom, out_hz_keep, out_shd, out_abort
    );

    modport slave (
        input  in_start, in_code, in_attr, in_hflip, in_vflip, in_hpos,
               in_ysub, in_hzoom, in_hz_keep, in_shd, eng_busy,
        output in_busy, out_start, out_code, out_attr, out_hflip, out_vflip,
               out_hpos, out_ysub, out_hzoom, out_hz_keep, out_shd, out_abort
    );

endinterface
`default_nettype wire

// File: rtl/jt053246_drq_fifo.sv
`default_nettype none
//============================================================================
// Module      : jt053246_drq_fifo
// Description : Small circular buffer of draw requests. Flush wins over push
//               and pop; a push while full or a pop while empty is ignored.
// Revision    : 1.0 - initial release
//============================================================================
module jt053246_drq_fifo
    import jt053246_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
)(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       cen,
    input  wire logic       i_push,
    input  wire logic       i_pop,
    input  wire logic       i_flush,
    input  drq_entry_t      i_din,
    output drq_entry_t      o_dout,
    output logic [AW:0]     o_count,
    output logic            o_full,
    output logic            o_empty
);

    localparam logic [AW-1:0] c_PTR_ONE = AW'(1);
    localparam logic [AW:0]   c_CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   c_CNT_FULL = (AW+1)'(DEPTH);

    drq_entry_t      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_full    = (r_count == c_CNT_FULL);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full  && !i_flush;
    assign w_do_pop  = i_pop  && !o_empty && !i_flush;

    // Storage write; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (cen && w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (cen) begin
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                case ({w_do_push, w_do_pop})
                    2'b10:   r_count <= r_count + c_CNT_ONE;
                    2'b01:   r_count <= r_count - c_CNT_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/jt053246_drq.sv
`default_nettype none
//============================================================================
// Module      : jt053246_drq
// Description : Draw-request queue between the object-table scanner and the
//               sprite draw engine. Buffers scanner requests, launches them
//               one at a time with a start/busy handshake, flushes stale
//               work and swaps the line-buffer bank at each line start, and
//               counts discarded requests.
// Revision    : 1.0 - initial release
//============================================================================
module jt053246_drq
    import jt053246_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
)(
    input  wire logic        rst,
    input  wire logic        clk,
    input  wire logic        cen,
    input  wire logic        hs,
    jt053246_drq_if.slave    bus,
    output logic             lbuf_bank,
    output logic [7:0]       drops
);

    drq_state_t  r_state;
    drq_state_t  w_state_nxt;
    logic        w_load;
    logic        r_hs_l;
    logic        w_line_start;
    logic        r_abort;
    logic        r_bank;
    logic [7:0]  r_drops;
    logic [7:0]  w_drop_add;
    drq_entry_t  w_in_entry;
    drq_entry_t  w_fifo_dout;
    drq_entry_t  r_out;
    logic [AW:0] w_count;
    logic        w_full;
    logic        w_empty;

    assign w_line_start = hs && !r_hs_l;

    assign w_in_entry = '{
        code:    bus.in_code,
        attr:    bus.in_attr,
        hflip:   bus.in_hflip,
        vflip:   bus.in_vflip,
        hpos:    bus.in_hpos,
        ysub:    bus.in_ysub,
        hzoom:   bus.in_hzoom,
        hz_keep: bus.in_hz_keep,
        shd:     bus.in_shd
    };

    jt053246_drq_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .cen     (cen),
        .i_push  (bus.in_start),
        .i_pop   (w_load),
        .i_flush (w_line_start),
        .i_din   (w_in_entry),
        .o_dout  (w_fifo_dout),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Launch sequencer: GUARD masks the cycle before the engine can raise busy
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        if (w_line_start) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        w_state_nxt = START;
                        w_load      = 1'b1;
                    end
                end
                START:   w_state_nxt = GUARD;
                GUARD:   w_state_nxt = WAIT;
                WAIT:    if (!bus.eng_busy) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Requests lost this cycle: the whole queue plus any same-cycle push on a
    // line start, otherwise a push that arrives while full
    always_comb begin
        w_drop_add = 8'd0;
        if (w_line_start) begin
            w_drop_add = 8'(w_count) + 8'(bus.in_start);
        end else if (bus.in_start && w_full) begin
            w_drop_add = 8'd1;
        end
    end

    // Sequencer state, hs history, abort pulse, bank and drop counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_hs_l  <= 1'b0;
            r_abort <= 1'b0;
            r_bank  <= 1'b0;
            r_drops <= 8'd0;
        end else if (cen) begin
            r_state <= w_state_nxt;
            r_hs_l  <= hs;
            r_abort <= w_line_start && (r_state != IDLE);
            if (w_line_start) r_bank <= ~r_bank;
            r_drops <= sat_add8(r_drops, w_drop_add);
        end
    end

    // Launched entry is held for the engine until the next launch, even
    // across a flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= '0;
        end else if (cen && w_load) begin
            r_out <= w_fifo_dout;
        end
    end

    assign bus.in_busy     = w_full;
    assign bus.out_start   = (r_state == START);
    assign bus.out_abort   = r_abort;
    assign bus.out_code    = r_out.code;
    assign bus.out_attr    = r_out.attr;
    assign bus.out_hflip   = r_out.hflip;
    assign bus.out_vflip   = r_out.vflip;
    assign bus.out_hpos    = r_out.hpos;
    assign bus.out_ysub    = r_out.ysub;
    assign bus.out_hzoom   = r_out.hzoom;
    assign bus.out_hz_keep = r_out.hz_keep;
    assign bus.out_shd     = r_out.shd;
    assign lbuf_bank       = r_bank;
    assign drops           = r_drops;

endmodule
`default_nettype wire
